serial_add_seq: RTL and testbench
=================================

// Module: serial_add_seq
// PURPOSE
//   Bit-serial adder sequencer: accepts two DWIDTH-bit operands over a valid/ready handshake,
//   adds them LSB-first one bit per clock with a carry flip-flop, and shifts each sum bit in at
//   the MSB of a right-shifting result register. Presents the full sum plus carry-out over a
//   valid/ready handshake. Drives and consumes the adder datapath's L2R shift stages.
// PARAMETERS
//   DWIDTH  8  operand/sum width; legal range >= 2
//   CNT_W   $clog2(DWIDTH)  localparam, bit-counter width
// PORTS
//   clk        in   1       single clock, rising edge
//   rst        in   1       synchronous, active-high reset
//   in_valid   in   1       operands a/b/cin valid
//   in_ready   out  1       block can accept operands
//   a          in   DWIDTH  operand A
//   b          in   DWIDTH  operand B
//   cin        in   1       carry-in
//   sub        in   1       subtract select; present only with SERADD_SUB_EN
//   out_valid  out  1       sum/cout valid
//   out_ready  in   1       consumer accepts result
//   sum        out  DWIDTH  result
//   cout       out  1       carry-out (not-borrow when subtracting)
//   busy       out  1       high in SHIFT
// BEHAVIOUR
//   Reset (rst=1 at an edge): state=IDLE, sum=0, cout=0, carry FF=0, counter=0, operand regs=0.
//   After reset: in_ready=1, out_valid=0, busy=0. Reset wins over every other event.
//   FSM states:
//     IDLE:  in_ready=1. in_valid&in_ready at an edge loads a/b, carry<=cin, cnt<=DWIDTH-1,
//            and moves to SHIFT.
//     SHIFT: on each edge, s=a_r[0]^b_r[0]^c and c<=maj(a_r[0],b_r[0],c).
//            a_r and b_r shift right with 0 fill; sum shifts right with s entering at MSB.
//            cnt decrements. On the edge where cnt==0: cout<=maj(...), then go to DONE.
//     DONE:  out_valid=1. sum/cout are stable. out_valid&out_ready at an edge moves to IDLE.
//   in_ready and out_valid are decoded from state only, with no comb path from in_valid or out_ready.
//   Latency: accept edge T0; shift edges T1..T(DWIDTH); out_valid high from the cycle after T(DWIDTH).
//   Throughput: one operation per DWIDTH+2 cycles when out_ready is held high.
//   in_valid while not IDLE: ignored; a/b changes do not affect an in-flight operation.
//   out_ready while not DONE: ignored. out_valid holds indefinitely under backpressure.
//   Arithmetic is modulo 2^DWIDTH; cout is bit DWIDTH of a+b+cin. sum during SHIFT is partial/undefined.
//   Reset mid-SHIFT or mid-DONE: the operation is discarded, with no out_valid pulse.
// CONFIGURATION
//   SERADD_SUB_EN defined: adds the sub port, sampled at accept.
//     sub=1 loads b_r=~b and forces carry<=1 (cin ignored), so the result is a-b.
//     cout=1 means no borrow (a>=b unsigned).
//   SERADD_SUB_EN undefined: no sub port, addition only; logic identical to sub=0.
// STRUCTURE
//   Package serial_add_pkg holds:
//     - state_t enum {IDLE=2'd0, SHIFT=2'd1, DONE=2'd2}
//     - a width-check function that fails elaboration if DWIDTH<2
//   Sub-module serial_fa (comb full adder: a,b,c -> s,co) with the carry FF in the parent.
//   The three shift registers and the counter are local to this module.
// TESTING (DWIDTH=8)
//   1. a=0x5A b=0x33 cin=0 -> sum=0x8D, cout=0; out_valid rises exactly 8 cycles after the accept edge.
//   2. a=0xFF b=0x01 cin=0 -> sum=0x00, cout=1. Also a=0xFF b=0xFF cin=1 -> sum=0xFF, cout=1.
//   3. Hold out_ready=0 for 20 cycles in DONE -> out_valid, sum, cout stable, in_ready=0.
//      New in_valid is ignored until the output handshake completes.
//   4. Assert rst at shift bit 4 -> next cycle in_ready=1, out_valid=0, sum=0.
//      A following op 0x01+0x01 gives 0x02.
//   5. SERADD_SUB_EN: 0x10-0x01 -> sum=0x0F, cout=1; 0x01-0x02 -> sum=0xFF, cout=0.
//   6. Random back-to-back ops with out_ready=1 -> match the a+b+cin model at one op per 10 cycles.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder sequencer: FSM state encoding and the
// elaboration-time operand width check.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // The shift datapath needs at least two bits to have a distinct LSB and MSB.
  function automatic bit dwidth_ok(input int unsigned dwidth);
    return (dwidth >= 2);
  endfunction

endpackage

// File: rtl/serial_fa.sv
// Purpose: single-bit combinational full adder feeding the serial carry loop.
// Latency: zero cycles, purely combinational.
// Backpressure: none; the parent sequencer decides when results are consumed.
module serial_fa (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_add_seq.sv
// Purpose: LSB-first bit-serial adder with valid/ready in and out; SERADD_SUB_EN adds a subtract port.
// Latency: accept edge, then DWIDTH shift edges; out_valid from the following cycle, DWIDTH+2 per op.
// Backpressure: result held in DONE until out_ready; in_ready is low for the whole operation.
module serial_add_seq
  import serial_add_pkg::*;
#(
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] a,
  input  logic [DWIDTH-1:0] b,
  input  logic              cin,
`ifdef SERADD_SUB_EN
  input  logic              sub,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] sum,
  output logic              cout,
  output logic              busy
);

  localparam int CNT_W = $clog2(DWIDTH);

  if (!dwidth_ok(DWIDTH)) begin : g_bad_width
    $error("serial_add_seq: DWIDTH must be >= 2");
  end

  state_t              state_q, state_d;
  logic [DWIDTH-1:0]   a_q, a_d;
  logic [DWIDTH-1:0]   b_q, b_d;
  logic [DWIDTH-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                carry_q, carry_d;
  logic                cout_q, cout_d;
  logic                sub_sel;
  logic                fa_s;
  logic                fa_co;

`ifdef SERADD_SUB_EN
  assign sub_sel = sub;
`else
  assign sub_sel = 1'b0;
`endif

  serial_fa u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .c  (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          // Subtraction is a + ~b + 1; the forced carry supplies the +1.
          b_d     = sub_sel ? ~b : b;
          carry_d = sub_sel ? 1'b1 : cin;
          cnt_d   = CNT_W'(DWIDTH - 1);
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        a_d     = {1'b0, a_q[DWIDTH-1:1]};
        b_d     = {1'b0, b_q[DWIDTH-1:1]};
        sum_d   = {fa_s, sum_q[DWIDTH-1:1]};
        carry_d = fa_co;
        if (cnt_q == '0) begin
          cout_d  = fa_co;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  // Handshake outputs come from state alone so no comb path crosses the block.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == SHIFT);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// Self-checking bench for serial_add_seq (DWIDTH=8): directed vectors, backpressure,
// mid-operation reset, optional subtract, and random back-to-back traffic vs an arithmetic model.
module tb_serial_add_seq;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] a = '0;
  logic [DW-1:0] b = '0;
  logic          cin = 1'b0;
  logic          sub = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] sum;
  logic          cout;
  logic          busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  serial_add_seq #(.DWIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SERADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  // Reference: {cout,sum}. Subtract is a-b modulo 2^DW with cout = no borrow.
  function automatic logic [DW:0] model(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                        input logic c, input logic s);
    int unsigned r;
    if (s) begin
      r = (int'(x) - int'(y) + (1 << DW)) % (1 << DW);
      return {(x >= y), r[DW-1:0]};
    end
    r = int'(x) + int'(y) + int'(c);
    return r[DW:0];
  endfunction

  // Launches one operation from IDLE and waits (bounded) for out_valid.
  task automatic do_op(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic c,
                       input logic s, output logic [DW-1:0] rs, output logic rc, output int lat);
    @(negedge clk);
    a = x; b = y; cin = c; sub = s; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    rs = sum;
    rc = cout;
  endtask

  task automatic complete_output();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (sum !== 8'h00) $display("FAIL reset_sum got=%h exp=00", sum); else n_pass++;
    n_checks++; if (cout !== 1'b0) $display("FAIL reset_cout got=%b exp=0", cout); else n_pass++;
  endtask

  task automatic test_basic();
    logic [DW-1:0] va [3] = '{8'h5A, 8'hFF, 8'hFF};
    logic [DW-1:0] vb [3] = '{8'h33, 8'h01, 8'hFF};
    logic          vc [3] = '{1'b0, 1'b0, 1'b1};
    logic [DW-1:0] es [3] = '{8'h8D, 8'h00, 8'hFF};
    logic          ec [3] = '{1'b0, 1'b1, 1'b1};
    logic [DW-1:0] rs;
    logic          rc;
    int            lat;
    for (int i = 0; i < 3; i++) begin
      do_op(va[i], vb[i], vc[i], 1'b0, rs, rc, lat);
      n_checks++; if (lat !== 8) $display("FAIL basic%0d_latency got=%0d exp=8", i, lat); else n_pass++;
      n_checks++; if (rs !== es[i]) $display("FAIL basic%0d_sum got=%h exp=%h", i, rs, es[i]); else n_pass++;
      n_checks++; if (rc !== ec[i]) $display("FAIL basic%0d_cout got=%b exp=%b", i, rc, ec[i]); else n_pass++;
      complete_output();
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b0) $display("FAIL basic%0d_drop_valid got=%b exp=0", i, out_valid); else n_pass++;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL basic%0d_ready_again got=%b exp=1", i, in_ready); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] rs;
    logic          rc;
    int            lat;
    do_op(8'h5A, 8'h33, 1'b0, 1'b0, rs, rc, lat);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = DW'($urandom);
      b = DW'($urandom);
      n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_valid cyc=%0d got=%b exp=1", i, out_valid); else n_pass++;
      n_checks++; if (sum !== 8'h8D) $display("FAIL bp_sum cyc=%0d got=%h exp=8d", i, sum); else n_pass++;
      n_checks++; if (cout !== 1'b0) $display("FAIL bp_cout cyc=%0d got=%b exp=0", i, cout); else n_pass++;
      n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready); else n_pass++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    complete_output();
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL bp_release got ready=%b valid=%b exp ready=1 valid=0", in_ready, out_valid); else n_pass++;
    do_op(8'h10, 8'h20, 1'b0, 1'b0, rs, rc, lat);
    n_checks++; if ({rc, rs} !== 9'h030) $display("FAIL bp_next_op got=%h exp=030", {rc, rs}); else n_pass++;
    complete_output();
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] rs;
    logic          rc;
    int            lat;
    int            seen;
    @(negedge clk);
    a = 8'h77; b = 8'h11; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_checks++; if (busy !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL mid_busy got busy=%b ready=%b exp busy=1 ready=0", busy, in_ready); else n_pass++;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) $display("FAIL mid_rst_ready got=%b exp=1", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_rst_valid got=%b exp=0", out_valid); else n_pass++;
    n_checks++; if (sum !== 8'h00) $display("FAIL mid_rst_sum got=%h exp=00", sum); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL mid_rst_busy got=%b exp=0", busy); else n_pass++;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_checks++; if (seen !== 0) $display("FAIL mid_rst_no_pulse got=%0d exp=0", seen); else n_pass++;
    do_op(8'h01, 8'h01, 1'b0, 1'b0, rs, rc, lat);
    n_checks++; if ({rc, rs} !== 9'h002) $display("FAIL mid_rst_next_op got=%h exp=002", {rc, rs}); else n_pass++;
    complete_output();
  endtask

`ifdef SERADD_SUB_EN
  task automatic test_sub();
    logic [DW-1:0] rs;
    logic          rc;
    int            lat;
    do_op(8'h10, 8'h01, 1'b0, 1'b1, rs, rc, lat);
    n_checks++; if (rs !== 8'h0F || rc !== 1'b1) $display("FAIL sub_10_01 got=%b_%h exp=1_0f", rc, rs); else n_pass++;
    complete_output();
    do_op(8'h01, 8'h02, 1'b1, 1'b1, rs, rc, lat);
    n_checks++; if (rs !== 8'hFF || rc !== 1'b0) $display("FAIL sub_01_02 got=%b_%h exp=0_ff", rc, rs); else n_pass++;
    complete_output();
    sub = 1'b0;
  endtask
`endif

  task automatic test_back_to_back();
    localparam int N = 25;
    logic [DW:0] exp_q[$];
    logic [DW:0] e;
    int issued = 0;
    int got = 0;
    int last_acc = -1;
    int cyc = 0;
    @(negedge clk);
    out_ready = 1'b1;
    while (got < N && cyc < N * 12 + 50) begin
      a   = DW'($urandom);
      b   = DW'($urandom);
      cin = 1'(($urandom));
`ifdef SERADD_SUB_EN
      sub = 1'($urandom);
`endif
      in_valid = (issued < N);
      if (out_valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL b2b_unexpected cyc=%0d got=%b_%h exp=none", cyc, cout, sum);
        end else begin
          e = exp_q.pop_front();
          if ({cout, sum} !== e) $display("FAIL b2b_result n=%0d got=%h exp=%h", got, {cout, sum}, e);
          else n_pass++;
        end
        got++;
      end
      if (in_ready && in_valid) begin
        exp_q.push_back(model(a, b, cin, sub));
        if (last_acc >= 0) begin
          n_checks++;
          if (cyc - last_acc !== 10) $display("FAIL b2b_interval got=%0d exp=10", cyc - last_acc);
          else n_pass++;
        end
        last_acc = cyc;
        issued++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sub       = 1'b0;
    n_checks++; if (got !== N) $display("FAIL b2b_count got=%0d exp=%0d", got, N); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid();
`ifdef SERADD_SUB_EN
    test_sub();
`endif
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
